// File: rtl/regfile_bypass.sv
// regfile_bypass: multi-ported register file with byte-lane masked writes,
// optional same-cycle write-to-read forwarding and a per-register busy
// scoreboard used by decode to detect pending producers.
module regfile_bypass #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 8,
  parameter int AW     = 3,
  parameter int BYPASS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [AW-1:0]      raddr1,
  input  logic [AW-1:0]      raddr2,
  output logic [WIDTH-1:0]   rdata1,
  output logic [WIDTH-1:0]   rdata2,
  output logic               busy1,
  output logic               busy2,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [WIDTH/8-1:0] wbe,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               issue,
  input  logic [AW-1:0]      issue_addr
);

  localparam int NLANES = WIDTH / 8;
  localparam bit BYP_EN = (BYPASS != 0);

  // Architectural state and its next-state values
  logic [WIDTH-1:0] mem_q [NREGS];
  logic [WIDTH-1:0] mem_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Bit-level write mask expanded from the byte-lane enables
  logic [WIDTH-1:0] lane_mask;

  // One-hot write / issue decode; out-of-range addresses match nothing,
  // which is what makes writes and issues to them harmless no-ops.
  logic [NREGS-1:0] wr_sel;
  logic [NREGS-1:0] iss_sel;

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    assign lane_mask[8*gi +: 8] = {8{wbe[gi]}};
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_dec
    assign wr_sel[gi]  = we    && (waddr      == AW'(gi));
    assign iss_sel[gi] = issue && (issue_addr == AW'(gi));
  end

  // Next state: merge enabled lanes on write; a new issue outranks a
  // retiring write to the same register, so set wins over clear.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      mem_d[i]  = mem_q[i];
      busy_d[i] = busy_q[i];
      if (wr_sel[i]) begin
        mem_d[i]  = (mem_q[i] & ~lane_mask) | (wdata & lane_mask);
        busy_d[i] = 1'b0;
      end
      if (iss_sel[i]) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  // State register; reset overrides any write or issue in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  // Read ports: both share the same structure, gathered into small arrays
  logic [AW-1:0]    raddr_p [2];
  logic [WIDTH-1:0] rdata_p [2];
  logic             busy_p  [2];

  assign raddr_p[0] = raddr1;
  assign raddr_p[1] = raddr2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [WIDTH-1:0] stored;
    logic             stored_busy;
    logic             addr_ok;
    logic             fwd;
    logic [WIDTH-1:0] rdata_c;
    logic             busy_c;

    // Asynchronous lookup; an address past the last register reads as zero
    always_comb begin
      stored      = '0;
      stored_busy = 1'b0;
      addr_ok     = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        if (raddr_p[gi] == AW'(i)) begin
          stored      = mem_q[i];
          stored_busy = busy_q[i];
          addr_ok     = 1'b1;
        end
      end
    end

    // Forwarding: present exactly the value the register will hold after
    // this edge, and report it not busy since the operand is available now.
    // A simultaneous issue to the same register only shows up next cycle.
    always_comb begin
      fwd     = BYP_EN && addr_ok && we && (waddr == raddr_p[gi]);
      rdata_c = stored;
      busy_c  = stored_busy;
      if (fwd) begin
        rdata_c = (stored & ~lane_mask) | (wdata & lane_mask);
        busy_c  = 1'b0;
      end
    end

    assign rdata_p[gi] = rdata_c;
    assign busy_p[gi]  = busy_c;
  end

  assign rdata1 = rdata_p[0];
  assign rdata2 = rdata_p[1];
  assign busy1  = busy_p[0];
  assign busy2  = busy_p[1];

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: forwarding and non-forwarding 16-bit
// instances share stimulus from a vector table; a 32-bit, 6-register
// instance covers out-of-range addressing and per-lane writes.
module tb_regfile_bypass;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two 16-bit instances
  logic        rst;
  logic [2:0]  raddr1, raddr2, waddr, issue_addr;
  logic        we, issue;
  logic [1:0]  wbe;
  logic [15:0] wdata;
  logic [15:0] b_rdata1, b_rdata2, n_rdata1, n_rdata2;
  logic        b_busy1, b_busy2, n_busy1, n_busy2;

  // Stimulus for the wide instance
  logic [2:0]  w_raddr1, w_raddr2, w_waddr, w_issue_addr;
  logic        w_we, w_issue;
  logic [3:0]  w_wbe;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata1, w_rdata2;
  logic        w_busy1, w_busy2;

  regfile_bypass #(.WIDTH(16), .NREGS(8), .AW(3), .BYPASS(1)) dut_b (
    .clk(clk), .reset(rst), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(b_rdata1), .rdata2(b_rdata2), .busy1(b_busy1), .busy2(b_busy2),
    .we(we), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .issue(issue), .issue_addr(issue_addr));

  regfile_bypass #(.WIDTH(16), .NREGS(8), .AW(3), .BYPASS(0)) dut_n (
    .clk(clk), .reset(rst), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(n_rdata1), .rdata2(n_rdata2), .busy1(n_busy1), .busy2(n_busy2),
    .we(we), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .issue(issue), .issue_addr(issue_addr));

  regfile_bypass #(.WIDTH(32), .NREGS(6), .AW(3), .BYPASS(1)) dut_w (
    .clk(clk), .reset(rst), .raddr1(w_raddr1), .raddr2(w_raddr2),
    .rdata1(w_rdata1), .rdata2(w_rdata2), .busy1(w_busy1), .busy2(w_busy2),
    .we(w_we), .waddr(w_waddr), .wbe(w_wbe), .wdata(w_wdata),
    .issue(w_issue), .issue_addr(w_issue_addr));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        we;
    logic [2:0]  waddr;
    logic [1:0]  wbe;
    logic [15:0] wdata;
    logic        iss;
    logic [2:0]  ia;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [15:0] b_rd1;
    logic [15:0] b_rd2;
    logic        b_bz1;
    logic        b_bz2;
    logic [15:0] n_rd1;
    logic [15:0] n_rd2;
    logic        n_bz1;
    logic        n_bz2;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  initial begin
    logic [31:0] exp5;
    logic [7:0]  lane_byte;

    //        rst we wa wbe   wdata  iss ia ra1 ra2 | b_rd1   b_rd2   bb1 bb2 | n_rd1   n_rd2   nb1 nb2
    tbl[0]  = '{0, 1, 3, 2'b11, 16'h1234, 0, 0, 3, 0, 16'h1234, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0};
    tbl[1]  = '{0, 1, 3, 2'b01, 16'hABCD, 0, 0, 3, 3, 16'h12CD, 16'h12CD, 0, 0, 16'h1234, 16'h1234, 0, 0};
    tbl[2]  = '{0, 0, 0, 2'b00, 16'h0000, 0, 0, 3, 5, 16'h12CD, 16'h0000, 0, 0, 16'h12CD, 16'h0000, 0, 0};
    tbl[3]  = '{0, 1, 5, 2'b10, 16'h7700, 0, 0, 5, 3, 16'h7700, 16'h12CD, 0, 0, 16'h0000, 16'h12CD, 0, 0};
    tbl[4]  = '{0, 0, 0, 2'b00, 16'h0000, 1, 2, 5, 2, 16'h7700, 16'h0000, 0, 0, 16'h7700, 16'h0000, 0, 0};
    tbl[5]  = '{0, 0, 0, 2'b00, 16'h0000, 0, 0, 2, 5, 16'h0000, 16'h7700, 1, 0, 16'h0000, 16'h7700, 1, 0};
    tbl[6]  = '{0, 1, 2, 2'b11, 16'h0042, 0, 0, 2, 2, 16'h0042, 16'h0042, 0, 0, 16'h0000, 16'h0000, 1, 1};
    tbl[7]  = '{0, 0, 0, 2'b00, 16'h0000, 0, 0, 2, 4, 16'h0042, 16'h0000, 0, 0, 16'h0042, 16'h0000, 0, 0};
    tbl[8]  = '{0, 0, 0, 2'b00, 16'h0000, 1, 4, 4, 2, 16'h0000, 16'h0042, 0, 0, 16'h0000, 16'h0042, 0, 0};
    tbl[9]  = '{0, 1, 4, 2'b11, 16'hBEEF, 1, 4, 4, 7, 16'hBEEF, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0};
    tbl[10] = '{0, 0, 0, 2'b00, 16'h0000, 0, 0, 4, 3, 16'hBEEF, 16'h12CD, 1, 0, 16'hBEEF, 16'h12CD, 1, 0};
    tbl[11] = '{0, 1, 4, 2'b00, 16'hFFFF, 0, 0, 4, 3, 16'hBEEF, 16'h12CD, 0, 0, 16'hBEEF, 16'h12CD, 1, 0};
    tbl[12] = '{0, 0, 0, 2'b00, 16'h0000, 0, 0, 4, 5, 16'hBEEF, 16'h7700, 0, 0, 16'hBEEF, 16'h7700, 0, 0};
    tbl[13] = '{0, 0, 0, 2'b00, 16'h0000, 1, 1, 1, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0};
    tbl[14] = '{0, 0, 0, 2'b00, 16'h0000, 1, 1, 1, 4, 16'h0000, 16'hBEEF, 1, 0, 16'h0000, 16'hBEEF, 1, 0};
    tbl[15] = '{0, 1, 1, 2'b01, 16'h55AA, 0, 0, 1, 1, 16'h00AA, 16'h00AA, 0, 0, 16'h0000, 16'h0000, 1, 1};
    tbl[16] = '{0, 0, 0, 2'b00, 16'h0000, 0, 0, 1, 0, 16'h00AA, 16'h0000, 0, 0, 16'h00AA, 16'h0000, 0, 0};
    tbl[17] = '{1, 1, 0, 2'b11, 16'hFFFF, 1, 3, 4, 0, 16'hBEEF, 16'hFFFF, 0, 0, 16'hBEEF, 16'h0000, 0, 0};
    tbl[18] = '{0, 0, 0, 2'b00, 16'h0000, 0, 0, 4, 3, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0};
    tbl[19] = '{0, 0, 0, 2'b00, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0};
    tbl[20] = '{0, 0, 0, 2'b00, 16'h0000, 0, 0, 2, 5, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0};

    // Reset for two edges while a full write is offered; it must be discarded
    rst = 1'b1; we = 1'b1; waddr = 3'd3; wbe = 2'b11; wdata = 16'hFFFF;
    issue = 1'b1; issue_addr = 3'd3; raddr1 = 3'd0; raddr2 = 3'd0;
    w_we = 1'b1; w_waddr = 3'd2; w_wbe = 4'hF; w_wdata = 32'hFFFF_FFFF;
    w_issue = 1'b0; w_issue_addr = 3'd0; w_raddr1 = 3'd0; w_raddr2 = 3'd0;
    repeat (2) @(posedge clk);

    // Every address reads zero and not busy after reset
    for (int a = 0; a < 8; a++) begin
      #1;
      rst = 1'b0; we = 1'b0; issue = 1'b0; w_we = 1'b0;
      raddr1 = 3'(a); raddr2 = 3'(7 - a);
      @(negedge clk);
      $display("reset-read a=%0d b_rd1=%h b_rd2=%h n_rd1=%h", a, b_rdata1, b_rdata2, n_rdata1);
      chk($sformatf("rst b_rd1 a%0d", a), 32'(b_rdata1), 32'h0);
      chk($sformatf("rst b_rd2 a%0d", a), 32'(b_rdata2), 32'h0);
      chk($sformatf("rst b_bz a%0d", a), {30'b0, b_busy1, b_busy2}, 32'h0);
      chk($sformatf("rst n_rd1 a%0d", a), 32'(n_rdata1), 32'h0);
      @(posedge clk);
    end

    // Table-driven vectors: outputs checked before the edge that commits them
    for (int k = 0; k < NV; k++) begin
      #1;
      rst = tbl[k].rst; we = tbl[k].we; waddr = tbl[k].waddr; wbe = tbl[k].wbe;
      wdata = tbl[k].wdata; issue = tbl[k].iss; issue_addr = tbl[k].ia;
      raddr1 = tbl[k].ra1; raddr2 = tbl[k].ra2;
      @(negedge clk);
      $display("vec %0d ra1=%0d ra2=%0d b=%h/%h/%b%b n=%h/%h/%b%b", k, raddr1, raddr2,
               b_rdata1, b_rdata2, b_busy1, b_busy2, n_rdata1, n_rdata2, n_busy1, n_busy2);
      chk($sformatf("v%0d b_rd1", k), 32'(b_rdata1), 32'(tbl[k].b_rd1));
      chk($sformatf("v%0d b_rd2", k), 32'(b_rdata2), 32'(tbl[k].b_rd2));
      chk($sformatf("v%0d b_bz1", k), 32'(b_busy1), 32'(tbl[k].b_bz1));
      chk($sformatf("v%0d b_bz2", k), 32'(b_busy2), 32'(tbl[k].b_bz2));
      chk($sformatf("v%0d n_rd1", k), 32'(n_rdata1), 32'(tbl[k].n_rd1));
      chk($sformatf("v%0d n_rd2", k), 32'(n_rdata2), 32'(tbl[k].n_rd2));
      chk($sformatf("v%0d n_bz1", k), 32'(n_busy1), 32'(tbl[k].n_bz1));
      chk($sformatf("v%0d n_bz2", k), 32'(n_busy2), 32'(tbl[k].n_bz2));
      @(posedge clk);
    end

    // Wide instance: writes and issues to addresses 7 and 6 are ignored
    #1;
    rst = 1'b0; we = 1'b0; issue = 1'b0;
    w_we = 1'b1; w_waddr = 3'd7; w_wbe = 4'hF; w_wdata = 32'hDEAD_BEEF;
    w_issue = 1'b1; w_issue_addr = 3'd7; w_raddr1 = 3'd7; w_raddr2 = 3'd6;
    @(negedge clk);
    $display("wide oor-write a=7 rd1=%h rd2=%h bz=%b%b", w_rdata1, w_rdata2, w_busy1, w_busy2);
    chk("w oor7 rd1", w_rdata1, 32'h0);
    chk("w oor7 rd2", w_rdata2, 32'h0);
    @(posedge clk);
    #1;
    w_waddr = 3'd6; w_wdata = 32'hCAFE_F00D; w_issue_addr = 3'd6;
    w_raddr1 = 3'd6; w_raddr2 = 3'd7;
    @(negedge clk);
    $display("wide oor-write a=6 rd1=%h rd2=%h bz=%b%b", w_rdata1, w_rdata2, w_busy1, w_busy2);
    chk("w oor6 rd1", w_rdata1, 32'h0);
    chk("w oor6 bz1", 32'(w_busy1), 32'h0);
    @(posedge clk);
    #1;
    w_we = 1'b0; w_issue = 1'b0; w_raddr1 = 3'd7; w_raddr2 = 3'd6;
    @(negedge clk);
    $display("wide oor-read rd1=%h rd2=%h bz=%b%b", w_rdata1, w_rdata2, w_busy1, w_busy2);
    chk("w oor rd1 after", w_rdata1, 32'h0);
    chk("w oor rd2 after", w_rdata2, 32'h0);
    chk("w oor bz after", {30'b0, w_busy1, w_busy2}, 32'h0);
    @(posedge clk);

    // No in-range register was touched by the ignored writes or issues
    for (int a = 0; a < 6; a++) begin
      #1;
      w_raddr1 = 3'(a); w_raddr2 = 3'(5 - a);
      @(negedge clk);
      $display("wide alias-read a=%0d rd1=%h bz1=%b", a, w_rdata1, w_busy1);
      chk($sformatf("w alias rd1 a%0d", a), w_rdata1, 32'h0);
      chk($sformatf("w alias bz1 a%0d", a), 32'(w_busy1), 32'h0);
      @(posedge clk);
    end

    // Each of the four lanes of R5 written on its own
    exp5 = 32'h0;
    for (int i = 0; i < 4; i++) begin
      #1;
      lane_byte = 8'(8'h11 * (i + 1));
      w_we = 1'b1; w_waddr = 3'd5; w_wbe = 4'(1 << i); w_wdata = {4{lane_byte}};
      w_raddr1 = 3'd5; w_raddr2 = 3'd0;
      exp5[8*i +: 8] = lane_byte;
      @(negedge clk);
      $display("wide lane %0d wbe=%b rd1=%h", i, w_wbe, w_rdata1);
      chk($sformatf("w lane%0d bypass", i), w_rdata1, exp5);
      chk($sformatf("w lane%0d r0", i), w_rdata2, 32'h0);
      @(posedge clk);
    end
    #1;
    w_we = 1'b0; w_raddr1 = 3'd5; w_raddr2 = 3'd4;
    @(negedge clk);
    $display("wide lane final rd1=%h rd2=%h", w_rdata1, w_rdata2);
    chk("w lanes final", w_rdata1, 32'h4433_2211);
    chk("w r4 untouched", w_rdata2, 32'h0);
    @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
